// File: rtl/divider_pkg.sv
// Shared constants for the restoring divider: default operand width and FSM state encoding.
package divider_pkg;

    localparam int unsigned DIV_WIDTH = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    typedef enum logic [2:0] {
        StIdle  = S_IDLE,
        StLoad  = S_LOAD,
        StShift = S_SHIFT,
        StCheck = S_CHECK,
        StFin   = S_FIN,
        StErr   = S_ERR
    } state_t;

endpackage

// File: rtl/div_iter_cnt.sv
// Loadable down-counter tracking remaining divider iterations; saturates at zero.
module div_iter_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/div_ctrl.sv
// Restoring-divider control FSM: sequences load/shift/subtract strobes for the
// external X/Y/R/Q datapath and reports completion or divide-by-zero.
module div_ctrl
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             divisor_zero,
    input  logic             r_lt_y,
    output logic             x_ld,
    output logic             y_ld,
    output logic             r_clr,
    output logic             q_clr,
    output logic             x_sl,
    output logic             r_sl,
    output logic             r_ld,
    output logic             q_sl,
    output logic             q_bit,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter
);

    localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);

    state_t state;
    logic   cnt_zero;
    logic   last_iter;

    assign last_iter = (iter == ITER_ONE);

    div_iter_cnt #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == StLoad),
        .load_val (ITER_INIT),
        .dec      ((state == StCheck) && !cnt_zero),
        .cnt      (iter),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state <= divisor_zero ? StErr : StLoad;
                    end
                end
                StLoad:  state <= StShift;
                StShift: state <= StCheck;
                StCheck: state <= last_iter ? StFin : StShift;
                StFin:   state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Pure state decode; only CHECK looks at the datapath compare result.
    always_comb begin
        x_ld  = 1'b0;
        y_ld  = 1'b0;
        r_clr = 1'b0;
        q_clr = 1'b0;
        x_sl  = 1'b0;
        r_sl  = 1'b0;
        r_ld  = 1'b0;
        q_sl  = 1'b0;
        q_bit = 1'b0;
        done  = 1'b0;
        err   = 1'b0;
        busy  = (state != StIdle);
        case (state)
            StLoad: begin
                x_ld  = 1'b1;
                y_ld  = 1'b1;
                r_clr = 1'b1;
                q_clr = 1'b1;
            end
            StShift: begin
                x_sl = 1'b1;
                r_sl = 1'b1;
            end
            StCheck: begin
                q_sl  = 1'b1;
                q_bit = ~r_lt_y;
                r_ld  = ~r_lt_y;
            end
            StFin: begin
                done = 1'b1;
            end
            StErr: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural X/Y/R/Q datapath and a result scoreboard.
module tb_div_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          divisor_zero;
    logic          r_lt_y;
    logic          x_ld, y_ld, r_clr, q_clr, x_sl, r_sl, r_ld, q_sl, q_bit;
    logic          busy, done, err;
    logic [CW-1:0] iter;

    logic [W-1:0]  op_a, op_b;
    logic [W-1:0]  xr, yr, qr;
    logic [W:0]    rr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W:0]   r;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .divisor_zero (divisor_zero),
        .r_lt_y       (r_lt_y),
        .x_ld         (x_ld),
        .y_ld         (y_ld),
        .r_clr        (r_clr),
        .q_clr        (q_clr),
        .x_sl         (x_sl),
        .r_sl         (r_sl),
        .r_ld         (r_ld),
        .q_sl         (q_sl),
        .q_bit        (q_bit),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .iter         (iter)
    );

    // Behavioural datapath
    assign divisor_zero = (op_b == '0);
    assign r_lt_y       = (rr < {1'b0, yr});

    always @(posedge clk) begin
        if (x_ld) xr <= op_a;
        else if (x_sl) xr <= xr << 1;
        if (y_ld) yr <= op_b;
        if (r_clr) rr <= '0;
        else if (r_sl) rr <= {rr[W-1:0], xr[W-1]};
        else if (r_ld) rr <= rr - {1'b0, yr};
        if (q_clr) qr <= '0;
        else if (q_sl) qr <= {qr[W-2:0], q_bit};
    end

    function automatic logic [14:0] all_outs();
        return {x_ld, y_ld, r_clr, q_clr, x_sl, r_sl, r_ld, q_sl, q_bit, busy, done, err, iter};
    endfunction

    // One division; start is held for the whole run when hold=1.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                           input int lat, input string name);
        exp_t       e;
        int         n;
        int         ld_cyc, busy_cyc, nq;
        logic [W-1:0] qb, rl;
        bit         excl_bad, got;
        e.err = (b == '0);
        e.q   = e.err ? '0 : a / b;
        e.r   = e.err ? '0 : {1'b0, a % b};
        e.lat = lat;
        sb.push_back(e);
        op_a = a;
        op_b = b;
        start = 1'b1;
        ld_cyc = 0; busy_cyc = 0; nq = 0; qb = '0; rl = '0; excl_bad = 0; got = 0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (!hold) start = 1'b0;
            if (x_ld | y_ld | r_clr | q_clr) ld_cyc++;
            if (busy) busy_cyc++;
            if (q_sl) begin
                qb = {qb[W-2:0], q_bit};
                rl = {rl[W-2:0], r_ld};
                nq++;
            end
            if ((x_ld & x_sl) | (q_sl & q_clr) | (int'(r_ld) + int'(r_sl) + int'(r_clr) > 1))
                excl_bad = 1;
            if (done) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            void'(sb.pop_back());
            return;
        end
        e = sb.pop_front();
        if (n !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
        end
        checks++;
        if (err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b want %b", name, err, e.err);
        end
        checks++;
        if (e.err) begin
            if (ld_cyc !== 0 || nq !== 0 || busy_cyc !== 1) begin
                errors++;
                $display("FAIL %s err path: ld_cyc %0d nq %0d busy %0d want 0 0 1",
                         name, ld_cyc, nq, busy_cyc);
            end
        end else begin
            if (qr !== e.q || rr !== e.r) begin
                errors++;
                $display("FAIL %s result: Q=%0d R=%0d want Q=%0d R=%0d", name, qr, rr, e.q, e.r);
            end
            checks++;
            if (nq !== W || qb !== e.q || rl !== e.q) begin
                errors++;
                $display("FAIL %s strobes: nq %0d qbits %b r_ld %b want %0d %b %b",
                         name, nq, qb, rl, W, e.q, e.q);
            end
            checks++;
            if (ld_cyc !== 1 || busy_cyc !== 2 * W + 2 || excl_bad) begin
                errors++;
                $display("FAIL %s sequencing: load cycles %0d busy %0d excl_bad %0d want 1 %0d 0",
                         name, ld_cyc, busy_cyc, excl_bad, 2 * W + 2);
            end
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after done: busy %b done %b want 0 0", name, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = 4'd1;
        #2;
        checks++;
        if (all_outs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_active: outs %h want 0", all_outs());
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (all_outs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle: outs %h want 0", all_outs());
        end
    endtask

    task automatic test_basic();
        run_div(4'd13, 4'd3, 1'b0, 2 * W + 2, "div_13_3");
        run_div(4'd15, 4'd1, 1'b0, 2 * W + 2, "div_15_1");
        run_div(4'd2,  4'd7, 1'b0, 2 * W + 2, "div_2_7");
    endtask

    task automatic test_div_zero();
        run_div(4'd9, 4'd0, 1'b0, 1, "div_by_zero");
    endtask

    task automatic test_reset_midop();
        int  nchk;
        bit  seen_done;
        op_a = 4'd13; op_b = 4'd3; start = 1'b1;
        nchk = 0; seen_done = 0;
        for (int i = 0; i < 20 && nchk < 2; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (q_sl) nchk++;
            if (done) seen_done = 1;
        end
        checks++;
        if (nchk !== 2 || iter !== 3'd3) begin
            errors++;
            $display("FAIL midop_reach: checks seen %0d iter %0d want 2 3", nchk, iter);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== 15'd0) begin
            errors++;
            $display("FAIL midop_async: outs %h want 0", all_outs());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (done) seen_done = 1;
        @(posedge clk);
        #1;
        if (done) seen_done = 1;
        checks++;
        if (all_outs() !== 15'd0 || seen_done) begin
            errors++;
            $display("FAIL midop_abort: outs %h done_seen %0d want 0 0", all_outs(), seen_done);
        end
        run_div(4'd13, 4'd3, 1'b0, 2 * W + 2, "after_reset_13_3");
    endtask

    task automatic test_back_to_back();
        run_div(4'd9, 4'd2, 1'b1, 2 * W + 2, "b2b_first");
        run_div(4'd9, 4'd2, 1'b1, 2 * W + 3, "b2b_second");
        run_div(4'd9, 4'd2, 1'b1, 2 * W + 3, "b2b_third");
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy %b done %b want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_reset_midop();
        test_back_to_back();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Control unit for the restoring integer divider: sequences dividend (X), divisor (Y), remainder (R, WIDTH+1 bits) and quotient (Q) shift registers plus the external R-Y subtractor.
- Accepts a start pulse and checks the divide-by-zero flag.
- Issues per-cycle load/shift/clear strobes for WIDTH iterations, then reports done or err.
- Contains no data storage; the datapath supplies the status bits.

Parameters:
- WIDTH, 4, dividend/divisor/quotient width; R register is WIDTH+1 bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a division; sampled only in IDLE
- divisor_zero  in  1  datapath flag, Y input bus == 0; sampled with start
- r_lt_y  in  1  datapath compare, R < Y; valid in CHECK
- x_ld  out  1  load X from operand bus
- y_ld  out  1  load Y from operand bus
- r_clr  out  1  synchronous clear of R
- q_clr  out  1  synchronous clear of Q
- x_sl  out  1  shift X left; X msb feeds R right_in via datapath wiring
- r_sl  out  1  shift R left
- r_ld  out  1  load R with R-Y from subtractor
- q_sl  out  1  shift Q left
- q_bit  out  1  Q right_in value for this shift
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle divide-by-zero pulse, coincident with done
- iter  out  CNT_W  remaining iterations (debug/visibility)

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE and iter to 0.
  - All outputs are 0 while rst is high and in the first IDLE cycle.
  - Reset mid-division aborts immediately. No done or err is issued.
- States: IDLE, LOAD, SHIFT, CHECK, FIN, ERR.
- IDLE: all strobes 0.
  - start=1 and divisor_zero=1 -> ERR.
  - start=1 and divisor_zero=0 -> LOAD.
  - Otherwise stay in IDLE.
- LOAD: assert x_ld, y_ld, r_clr, q_clr; iter <= WIDTH; -> SHIFT.
- SHIFT: assert x_sl, r_sl; -> CHECK.
- CHECK (Mealy outputs on r_lt_y):
  - Assert q_sl with q_bit = ~r_lt_y.
  - Assert r_ld = ~r_lt_y.
  - iter <= iter-1.
  - If iter==1 on entry -> FIN, else -> SHIFT.
- FIN: done=1 for one cycle; -> IDLE.
- ERR: done=1, err=1 for one cycle. No load or shift strobe is issued; datapath registers are untouched. -> IDLE.
- Strobe exclusivity: at most one of {ld, sl, clr} is asserted per register per cycle.
- start while busy is ignored; it is not queued.
- Latency, start sampled in cycle 0:
  - LOAD in cycle 1.
  - SHIFT/CHECK pairs in cycles 2..2*WIDTH+1.
  - done in cycle 2*WIDTH+2 (cycle 10 for WIDTH=4).
  - ERR path: done/err in cycle 1.
- Back-to-back: start high in the FIN cycle is ignored. The next start is accepted in the following IDLE cycle.
- iter never wraps: the decrement occurs only in CHECK with iter >= 1.
- Outputs are combinational decodes of state, plus r_lt_y in CHECK. They are glitch-tolerant because every consumer is synchronous.

Decomposition:
- Shared package divider_pkg:
  - State encoding localparams S_IDLE..S_ERR, 3-bit.
  - DIV_WIDTH default constant, shared by the shift registers and div_ctrl.
- One natural sub-module: div_iter_cnt.
  - Loadable down-counter with load, dec and zero flag.
  - Same asynchronous reset.
- The FSM stays in div_ctrl.

Test Plan:
- Reset mid-op: assert rst in the 2nd CHECK of a 13/3 run -> next cycle state IDLE, all outputs 0, no done; a fresh start then completes normally.
- Bench with a behavioural datapath (X, Y, R, Q built from the team shift registers plus a subtractor and comparator):
  - 13/3, WIDTH=4, start in cycle 0 -> q_bit sequence 0,1,0,0; r_ld only in the 2nd CHECK; done in cycle 10; Q=4, R=1; err=0.
  - 15/1 -> q_bit 1,1,1,1; r_ld in every CHECK; Q=15, R=0; done in cycle 10.
  - 2/7 -> q_bit all 0; r_ld never asserted; Q=0, R=2.
- Divide by zero: start with divisor_zero=1 -> done=err=1 in cycle 1; no x_ld/y_ld/r_clr/q_clr seen; busy high for exactly 1 cycle.
- start held high continuously: successive 9/2 divisions -> done pulses every 11 cycles; start pulses while busy produce no extra LOAD; Q=4, R=1 each time.
